// File: rtl/alu8_seq_if.sv
// rtl/alu8_seq_if.sv - start/done handshake and operand/result bundle for alu8_seq
interface alu8_seq_if;
    logic        start;
    logic [1:0]  op_code;
    logic [7:0]  operand_A;
    logic [7:0]  operand_B;
    logic [15:0] alu_result;
    logic        alu_done;

    modport master (
        output start, op_code, operand_A, operand_B,
        input  alu_result, alu_done
    );

    modport slave (
        input  start, op_code, operand_A, operand_B,
        output alu_result, alu_done
    );
endinterface

// File: rtl/alu8_seq.sv
// rtl/alu8_seq.sv - 8-bit multi-cycle ALU: add/sub, signed Booth multiply, unsigned restoring divide
module alu8_seq (
    input  logic        clk,
    input  logic        reset,
    alu8_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDSUB  = 3'd1,
        MUL_RUN = 3'd2,
        DIV_RUN = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_sub;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [8:0]  r_acc;
    logic [7:0]  r_q;
    logic        r_q1;
    logic [3:0]  r_cnt;
    logic [15:0] r_result;
    logic        r_done;

    logic        w_accept;
    logic [7:0]  w_addsub;
    logic [8:0]  w_m9;
    logic [8:0]  w_booth_sum;
    logic [8:0]  w_shift;
    logic [9:0]  w_trial;

    // r_done also blocks acceptance in the first IDLE cycle after DONE
    assign w_accept = (r_state == IDLE) && bus.start && !r_done;
    assign w_addsub = r_sub ? (r_a - r_b) : (r_a + r_b);

    assign w_m9 = {r_a[7], r_a};
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_booth_sum = r_acc + w_m9;
            2'b10:   w_booth_sum = r_acc - w_m9;
            default: w_booth_sum = r_acc;
        endcase
    end

    assign w_shift = {r_acc[7:0], r_q[7]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!bus.op_code[1])     w_next_state = ADDSUB;
                    else if (bus.op_code[0]) w_next_state = DIV_RUN;
                    else                     w_next_state = MUL_RUN;
                end
            end
            ADDSUB:  w_next_state = DONE;
            MUL_RUN: if (r_cnt == 4'd8) w_next_state = DONE;
            DIV_RUN: if (r_cnt == 4'd8) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sub    <= 1'b0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_acc    <= 9'h000;
            r_q      <= 8'h00;
            r_q1     <= 1'b0;
            r_cnt    <= 4'd0;
            r_result <= 16'h0000;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sub <= bus.op_code[0];
                        r_a   <= bus.operand_A;
                        r_b   <= bus.operand_B;
                        r_acc <= 9'h000;
                        // Q holds the multiplier for MUL, the dividend for DIV
                        r_q   <= bus.op_code[0] ? bus.operand_A : bus.operand_B;
                        r_q1  <= 1'b0;
                        r_cnt <= 4'd0;
                    end
                end
                ADDSUB: r_result <= {8'h00, w_addsub};
                MUL_RUN: begin
                    if (r_cnt != 4'd8) begin
                        r_acc <= {w_booth_sum[8], w_booth_sum[8:1]};
                        r_q   <= {w_booth_sum[0], r_q[7:1]};
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_result <= {r_acc[7:0], r_q};
                    end
                end
                DIV_RUN: begin
                    if (r_cnt != 4'd8) begin
                        // A zero divisor always "fits", giving quotient FF and remainder = dividend
                        if (!w_trial[9]) begin
                            r_acc <= w_trial[8:0];
                            r_q   <= {r_q[6:0], 1'b1};
                        end else begin
                            r_acc <= w_shift;
                            r_q   <= {r_q[6:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_result <= {r_acc[7:0], r_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_result = r_result;
    assign bus.alu_done   = r_done;
endmodule

// File: tb/tb_alu8_seq.sv
// tb/tb_alu8_seq.sv - randomized self-checking bench for alu8_seq against an arithmetic reference model
module tb_alu8_seq;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu8_seq_if bus ();

    alu8_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, p;
        logic [15:0] r;
        case (op)
            2'b00: r = 16'((int'(a) + int'(b)) % 256);
            2'b01: r = 16'((int'(a) - int'(b) + 256) % 256);
            2'b10: begin
                sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
                sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
                p  = sa * sb;
                r  = p[15:0];
            end
            default: begin
                if (b == 8'd0) r = {a, 8'hFF};
                else           r = {8'(a % b), 8'(a / b)};
            end
        endcase
        return r;
    endfunction

    task automatic watch_quiet(input string tag, input int cycles, input logic [15:0] exp_res);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.alu_done) pulses++;
        end
        check({tag, "_extra_done"}, pulses, 0);
        check({tag, "_hold"}, bus.alu_result, exp_res);
    endtask

    // noisy: scramble start/operands while busy; poke: assert start during the done cycle
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input bit noisy, input bit poke);
        logic [15:0] exp;
        int n;
        bit seen;
        exp = ref_model(op, a, b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_code   = op;
        bus.operand_A = a;
        bus.operand_B = b;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.alu_done) begin
                seen = 1;
                bus.start   = poke;
                bus.op_code = 2'b00;
            end else if (noisy) begin
                bus.start     = 1'($urandom_range(0, 1));
                bus.op_code   = 2'($urandom);
                bus.operand_A = 8'($urandom);
                bus.operand_B = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        check({tag, "_latency"}, n, op[1] ? 11 : 3);
        check({tag, "_result"}, bus.alu_result, exp);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_width"}, bus.alu_done, 0);
        watch_quiet(tag, 12, exp);
    endtask

    initial begin
        logic [1:0] rop;
        logic [7:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op_code   = 2'b00;
        bus.operand_A = 8'h00;
        bus.operand_B = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_result", bus.alu_result, 0);
        check("reset_done", bus.alu_done, 0);
        reset = 1'b0;
        check("idle_no_done", bus.alu_done, 0);

        run_op("add_20_15",  2'b00, 8'd20,  8'd15,  0, 0);
        run_op("add_carry",  2'b00, 8'd200, 8'd100, 0, 0);
        run_op("sub_30_10",  2'b01, 8'd30,  8'd10,  0, 0);
        run_op("sub_borrow", 2'b01, 8'd5,   8'd10,  0, 0);
        run_op("mul_7_6",    2'b10, 8'd7,   8'd6,   0, 0);
        run_op("mul_80_80",  2'b10, 8'h80,  8'h80,  0, 0);
        run_op("mul_7f_80",  2'b10, 8'h7F,  8'h80,  0, 0);
        run_op("mul_ff_ff",  2'b10, 8'hFF,  8'hFF,  0, 0);
        run_op("div_200_13", 2'b11, 8'd200, 8'd13,  0, 0);
        run_op("div_by_0",   2'b11, 8'd9,   8'd0,   0, 0);
        run_op("mul_noisy",  2'b10, 8'hC3,  8'h5A,  1, 0);
        run_op("b2b_poke",   2'b01, 8'd77,  8'd99,  0, 1);

        check("lit_add", ref_model(2'b00, 8'd200, 8'd100), 16'h002C);
        check("lit_div", ref_model(2'b11, 8'd200, 8'd13), 16'h050F);

        @(negedge clk);
        bus.start     = 1'b1;
        bus.op_code   = 2'b11;
        bus.operand_A = 8'd250;
        bus.operand_B = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_result", bus.alu_result, 0);
        check("abort_done", bus.alu_done, 0);
        @(negedge clk);
        reset = 1'b0;
        watch_quiet("abort", 14, 16'h0000);
        run_op("after_abort_add", 2'b00, 8'd20, 8'd15, 0, 0);

        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom);
            ra  = 8'($urandom);
            rb  = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            run_op("rand", rop, ra, rb, (i % 3 == 0), (i % 5 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
